// File: rtl/mod_enc_round_ctrl.sv
// AES-256 encryption round sequencer: walks the datapath through INIT_ARK, then SUB/SHIFT/(MIX)/ARK per round.
// Build option: define ENC_ROUND_CTRL_ABORT_EN to add the abort input that drops an in-flight block.
module mod_enc_round_ctrl #(
   parameter int NR     = 14,
   parameter int KIDX_W = 4
) (
   input  logic              clk,
   input  logic              reset,
`ifdef ENC_ROUND_CTRL_ABORT_EN
   input  logic              abort,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              en_sub,
   output logic              en_shift,
   output logic              en_mix,
   output logic              en_ark,
   output logic [1:0]        ark_src,
   output logic [KIDX_W-1:0] key_idx,
   output logic              busy,
   output logic [2:0]        dbg_state
);

   // Handshakes: a block is taken on a rising edge where in_valid && in_ready; the
   // ciphertext is released on a rising edge where out_valid && out_ready.

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INIT_ARK = 3'd1,
      ST_SUB      = 3'd2,
      ST_SHIFT    = 3'd3,
      ST_MIX      = 3'd4,
      ST_ARK      = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   localparam logic [KIDX_W-1:0] ROUND_LAST = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] ROUND_ONE  = KIDX_W'(1);

   localparam logic [1:0] SRC_PLAIN = 2'd0;
   localparam logic [1:0] SRC_MIX   = 2'd1;
   localparam logic [1:0] SRC_SHIFT = 2'd2;

   state_t            state_q, state_d;
   logic [KIDX_W-1:0] round_q, round_d;
   logic              last_round;
   logic              abort_req;

   assign last_round = (round_q >= ROUND_LAST);

`ifdef ENC_ROUND_CTRL_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_INIT_ARK;
               round_d = '0;
            end
         end
         ST_INIT_ARK: begin
            state_d = ST_SUB;
            round_d = ROUND_ONE;
         end
         ST_SUB: begin
            state_d = ST_SHIFT;
         end
         // The final round has no mixColumns; its key is added straight to shiftRows.
         ST_SHIFT: begin
            state_d = last_round ? ST_ARK : ST_MIX;
         end
         ST_MIX: begin
            state_d = ST_ARK;
         end
         ST_ARK: begin
            if (last_round) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SUB;
               round_d = round_q + ROUND_ONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
               round_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            round_d = '0;
         end
      endcase
      if (abort_req && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         round_d = '0;
      end
   end

   // Outputs are a pure decode of state_q/round_q so no input reaches an output in the same cycle.
   always_comb begin
      en_sub    = 1'b0;
      en_shift  = 1'b0;
      en_mix    = 1'b0;
      en_ark    = 1'b0;
      ark_src   = SRC_PLAIN;
      out_valid = 1'b0;
      in_ready  = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         ST_INIT_ARK: begin
            en_ark  = 1'b1;
            ark_src = SRC_PLAIN;
         end
         ST_SUB:   en_sub   = 1'b1;
         ST_SHIFT: en_shift = 1'b1;
         ST_MIX:   en_mix   = 1'b1;
         ST_ARK: begin
            en_ark  = 1'b1;
            ark_src = last_round ? SRC_SHIFT : SRC_MIX;
         end
         ST_DONE:  out_valid = 1'b1;
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign key_idx   = round_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mod_enc_round_ctrl.sv
// Bench for mod_enc_round_ctrl: NR=14 and NR=10 instances checked against a per-cycle expected schedule.
// The abort scenario is exercised only when ENC_ROUND_CTRL_ABORT_EN is defined.
module tb_mod_enc_round_ctrl;

   localparam int NR_A = 14;
   localparam int NR_B = 10;
   localparam int KW   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic          en_sub_a, en_shift_a, en_mix_a, en_ark_a, busy_a;
   logic [1:0]    ark_src_a;
   logic [KW-1:0] key_idx_a;
   logic [2:0]    dbg_state_a;
   logic          rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic          en_sub_b, en_shift_b, en_mix_b, en_ark_b, busy_b;
   logic [1:0]    ark_src_b;
   logic [KW-1:0] key_idx_b;
   logic [2:0]    dbg_state_b;
`ifdef ENC_ROUND_CTRL_ABORT_EN
   logic          abort_a, abort_b;
`endif

   mod_enc_round_ctrl #(.NR(NR_A), .KIDX_W(KW)) dut_a (
      .clk(clk), .reset(rst_a),
`ifdef ENC_ROUND_CTRL_ABORT_EN
      .abort(abort_a),
`endif
      .in_valid(in_valid_a), .in_ready(in_ready_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .en_sub(en_sub_a), .en_shift(en_shift_a), .en_mix(en_mix_a), .en_ark(en_ark_a),
      .ark_src(ark_src_a), .key_idx(key_idx_a), .busy(busy_a), .dbg_state(dbg_state_a)
   );

   mod_enc_round_ctrl #(.NR(NR_B), .KIDX_W(KW)) dut_b (
      .clk(clk), .reset(rst_b),
`ifdef ENC_ROUND_CTRL_ABORT_EN
      .abort(abort_b),
`endif
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .en_sub(en_sub_b), .en_shift(en_shift_b), .en_mix(en_mix_b), .en_ark(en_ark_b),
      .ark_src(ark_src_b), .key_idx(key_idx_b), .busy(busy_b), .dbg_state(dbg_state_b)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [12:0] exp_q[$];

   // Observation word: {en_sub, en_shift, en_mix, en_ark, ark_src, key_idx, out_valid, in_ready, busy}
   function automatic logic [12:0] mk(input logic s, input logic sh, input logic m, input logic a,
                                      input logic [1:0] src, input int key,
                                      input logic ov, input logic ir, input logic bz);
      logic [3:0] k;
      k = key[3:0];
      return {s, sh, m, a, src, k, ov, ir, bz};
   endfunction

   function automatic logic [12:0] idle_p();
      return mk(0, 0, 0, 0, 2'd0, 0, 0, 1, 0);
   endfunction

   function automatic logic [12:0] get_obs(input int which);
      if (which == 0)
         return {en_sub_a, en_shift_a, en_mix_a, en_ark_a, ark_src_a, key_idx_a,
                 out_valid_a, in_ready_a, busy_a};
      return {en_sub_b, en_shift_b, en_mix_b, en_ark_b, ark_src_b, key_idx_b,
              out_valid_b, in_ready_b, busy_b};
   endfunction

   function automatic logic get_ov(input int which);
      return (which == 0) ? out_valid_a : out_valid_b;
   endfunction

   task automatic set_iv(input int which, input logic v);
      if (which == 0) in_valid_a = v; else in_valid_b = v;
   endtask

   task automatic set_or(input int which, input logic v);
      if (which == 0) out_ready_a = v; else out_ready_b = v;
   endtask

   task automatic set_rst(input int which, input logic v);
      if (which == 0) rst_a = v; else rst_b = v;
   endtask

`ifdef ENC_ROUND_CTRL_ABORT_EN
   task automatic set_ab(input int which, input logic v);
      if (which == 0) abort_a = v; else abort_b = v;
   endtask
`endif

   task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected per-cycle schedule after the accepting edge, straight from the AES round structure.
   task automatic build_exp(input int nr);
      exp_q.delete();
      exp_q.push_back(mk(0, 0, 0, 1, 2'd0, 0, 0, 0, 1));
      for (int r = 1; r < nr; r++) begin
         exp_q.push_back(mk(1, 0, 0, 0, 2'd0, r, 0, 0, 1));
         exp_q.push_back(mk(0, 1, 0, 0, 2'd0, r, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 1, 0, 2'd0, r, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 0, 1, 2'd1, r, 0, 0, 1));
      end
      exp_q.push_back(mk(1, 0, 0, 0, 2'd0, nr, 0, 0, 1));
      exp_q.push_back(mk(0, 1, 0, 0, 2'd0, nr, 0, 0, 1));
      exp_q.push_back(mk(0, 0, 0, 1, 2'd2, nr, 0, 0, 1));
   endtask

   task automatic watch_no_ov(input int which, input int cycles, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (get_ov(which)) seen = 1'b1;
      end
      chk(tag, {12'b0, seen}, 13'b0);
   endtask

   // stop_at: schedule index at which the block is interrupted (-1 = run to completion).
   task automatic run_block(input int which, input int nr, input bit toggle, input int hold,
                            input int stop_at, input bit use_abort);
      int idx;
      int acc_cyc;
      logic [12:0] e;
      logic [12:0] done_p;
      build_exp(nr);
      done_p = mk(0, 0, 0, 0, 2'd0, nr, 1, 0, 1);
      @(negedge clk);
      chk($sformatf("idle_before_u%0d", which), get_obs(which), idle_p());
      set_iv(which, 1'b1);
      set_or(which, 1'b0);
      @(negedge clk);
      acc_cyc = cyc;
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("seq_u%0d_i%0d", which, idx), get_obs(which), e);
         if (idx == stop_at) begin
            if (use_abort) begin
`ifdef ENC_ROUND_CTRL_ABORT_EN
               set_iv(which, 1'b0);
               set_ab(which, 1'b1);
               @(negedge clk);
               set_ab(which, 1'b0);
               chk("abort_to_idle", get_obs(which), idle_p());
               watch_no_ov(which, 4 * nr + 8, "no_ov_after_abort");
`endif
            end else begin
               #2;
               set_rst(which, 1'b1);
               #1;
               chk("async_reset_values", get_obs(which), idle_p());
               set_iv(which, 1'b0);
               @(negedge clk);
               set_rst(which, 1'b0);
               watch_no_ov(which, 4 * nr + 8, "no_ov_after_reset");
            end
            return;
         end
         idx++;
         set_iv(which, toggle ? 1'($urandom_range(0, 1)) : 1'b0);
         @(negedge clk);
      end
      chk($sformatf("latency_u%0d", which), 13'(cyc - acc_cyc), 13'(4 * nr));
      for (int h = 0; h < hold; h++) begin
         chk($sformatf("done_hold_u%0d_h%0d", which, h), get_obs(which), done_p);
         set_iv(which, toggle ? 1'($urandom_range(0, 1)) : 1'b0);
         @(negedge clk);
      end
      chk($sformatf("done_u%0d", which), get_obs(which), done_p);
      set_or(which, 1'b1);
      set_iv(which, toggle);
      @(negedge clk);
      chk($sformatf("idle_after_u%0d", which), get_obs(which), idle_p());
      set_or(which, 1'b0);
      set_iv(which, 1'b0);
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      out_ready_a = 1'b0; out_ready_b = 1'b0;
`ifdef ENC_ROUND_CTRL_ABORT_EN
      abort_a = 1'b0; abort_b = 1'b0;
`endif
      #12;
      chk("reset_values_a", get_obs(0), idle_p());
      chk("reset_values_b", get_obs(1), idle_p());
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;

      // Plain block, immediate drain.
      run_block(0, NR_A, 1'b0, 0, -1, 1'b0);
      // Downstream stalls for 10 cycles.
      run_block(0, NR_A, 1'b0, 10, -1, 1'b0);
      // in_valid toggling while busy and during the DONE exit.
      run_block(0, NR_A, 1'b1, 3, -1, 1'b0);
      // Reset at round 7 SUB, then a clean block.
      run_block(0, NR_A, 1'b0, 0, 4 * 7 - 3, 1'b0);
      run_block(0, NR_A, 1'b0, 0, -1, 1'b0);
      // Short-key instance.
      run_block(1, NR_B, 1'b0, 0, -1, 1'b0);
      run_block(1, NR_B, 1'b1, 2, -1, 1'b0);
`ifdef ENC_ROUND_CTRL_ABORT_EN
      run_block(0, NR_A, 1'b0, 0, 4 * 3 - 3, 1'b1);
      run_block(0, NR_A, 1'b0, 0, -1, 1'b0);
`endif
      // Randomized blocks on both instances.
      for (int t = 0; t < 6; t++) begin
         int w;
         int gap;
         w = int'($urandom_range(0, 1));
         gap = int'($urandom_range(0, 4));
         for (int g = 0; g < gap; g++) @(negedge clk);
         run_block(w, (w == 0) ? NR_A : NR_B, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 6)), -1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
